// File: rtl/riscv_i32_irq_sequencer.sv
// Interrupt request sequencer: fixed-priority selection of 15 level sources, IDLE/REQUEST/HANDLER handshake.
// Define RISCV_I32_IRQ_NMI_EN to add the edge-triggered, nestable non-maskable interrupt.
module riscv_i32_irq_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] irq_in,
  input  logic [14:0] irq_enable,
  input  logic        global_ie,
  input  logic        halt,
  input  logic        interrupt_ack,
  input  logic        trap_ret,
`ifdef RISCV_I32_IRQ_NMI_EN
  input  logic        nmi,
`endif
  output logic        interrupt_req,
  output logic [3:0]  interrupt_number,
  output logic [2:0]  interrupt_to_mode,
  output logic [14:0] irq_pending,
  output logic        in_handler
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_HANDLER,
    ST_NMI_REQUEST,
    ST_NMI_HANDLER
  } state_t;

  localparam logic [3:0] NMI_NUMBER = 4'hF;

  state_t     state;
  state_t     state_next;
  logic [3:0] latched_number;
  logic [3:0] cand_number;
  logic       cand_valid;
  logic       latched_pending;
  logic       nmi_pending;
  logic       nmi_nested;

  assign interrupt_to_mode = 3'h3;

  // NOTE: reset is synchronous, so it lives inside the clocked block and only
  // acts on a rising edge; every state element below follows the same pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pending <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so that all
      // registers update together from pre-edge values.
      irq_pending <= irq_in & irq_enable;
    end
  end

  // Fixed priority: the loop runs upward so the highest set index wins.
  always_comb begin
    cand_valid  = 1'b0;
    cand_number = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (irq_pending[i]) begin
        cand_valid  = 1'b1;
        cand_number = 4'(i);
      end
    end
  end

  assign latched_pending = irq_pending[latched_number];

`ifdef RISCV_I32_IRQ_NMI_EN
  logic nmi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_q       <= 1'b0;
      nmi_pending <= 1'b0;
      nmi_nested  <= 1'b0;
    end else begin
      nmi_q <= nmi;
      // A fresh edge wins over the ack so a back-to-back NMI is never lost.
      if (nmi && !nmi_q) begin
        nmi_pending <= 1'b1;
      end else if (state == ST_NMI_REQUEST && interrupt_ack) begin
        nmi_pending <= 1'b0;
      end
      if (state_next == ST_NMI_REQUEST && state != ST_NMI_REQUEST) begin
        nmi_nested <= (state == ST_HANDLER);
      end
    end
  end
`else
  assign nmi_pending = 1'b0;
  assign nmi_nested  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      latched_number <= 4'd0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && state_next == ST_REQUEST) begin
        latched_number <= cand_number;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would infer a latch.
    state_next       = state;
    interrupt_req    = 1'b0;
    interrupt_number = 4'd0;
    in_handler       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (nmi_pending && !halt) begin
          state_next = ST_NMI_REQUEST;
        end else if (cand_valid && global_ie && !halt) begin
          state_next = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        interrupt_req    = 1'b1;
        interrupt_number = latched_number;
        // Ack beats any withdraw condition raised in the same cycle.
        if (interrupt_ack) begin
          state_next = ST_HANDLER;
        end else if (!latched_pending || !global_ie || halt) begin
          state_next = ST_IDLE;
        end else if (nmi_pending) begin
          state_next = ST_NMI_REQUEST;
        end
      end
      ST_HANDLER: begin
        in_handler = 1'b1;
        if (trap_ret) begin
          state_next = ST_IDLE;
        end else if (nmi_pending && !halt) begin
          state_next = ST_NMI_REQUEST;
        end
      end
      ST_NMI_REQUEST: begin
        interrupt_req    = 1'b1;
        interrupt_number = NMI_NUMBER;
        if (interrupt_ack) begin
          state_next = ST_NMI_HANDLER;
        end
      end
      ST_NMI_HANDLER: begin
        if (trap_ret) begin
          state_next = nmi_nested ? ST_HANDLER : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_i32_irq_sequencer.sv
// Directed self-checking bench for riscv_i32_irq_sequencer; the NMI scenario runs when RISCV_I32_IRQ_NMI_EN is defined.
module tb_riscv_i32_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] irq_in;
  logic [14:0] irq_enable;
  logic        global_ie;
  logic        halt;
  logic        interrupt_ack;
  logic        trap_ret;
`ifdef RISCV_I32_IRQ_NMI_EN
  logic        nmi;
`endif
  logic        interrupt_req;
  logic [3:0]  interrupt_number;
  logic [2:0]  interrupt_to_mode;
  logic [14:0] irq_pending;
  logic        in_handler;

  int checks = 0;
  int errors = 0;

  riscv_i32_irq_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .irq_in            (irq_in),
    .irq_enable        (irq_enable),
    .global_ie         (global_ie),
    .halt              (halt),
    .interrupt_ack     (interrupt_ack),
    .trap_ret          (trap_ret),
`ifdef RISCV_I32_IRQ_NMI_EN
    .nmi               (nmi),
`endif
    .interrupt_req     (interrupt_req),
    .interrupt_number  (interrupt_number),
    .interrupt_to_mode (interrupt_to_mode),
    .irq_pending       (irq_pending),
    .in_handler        (in_handler)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_req(input string tag, input logic req, input logic [3:0] num);
    check({tag, ".req"}, 32'(interrupt_req), 32'(req));
    check({tag, ".num"}, 32'(interrupt_number), 32'(num));
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; irq_enable = '0; global_ie = 1'b0;
    halt = 1'b0; interrupt_ack = 1'b0; trap_ret = 1'b0;
`ifdef RISCV_I32_IRQ_NMI_EN
    nmi = 1'b0;
`endif
    cycle(2);
    check_req("reset", 1'b0, 4'd0);
    check("reset.in_handler", 32'(in_handler), 32'd0);
    check("reset.pending", 32'(irq_pending), 32'd0);
    check("mode", 32'(interrupt_to_mode), 32'd3);
    reset = 1'b0;

    // Source 7: request two cycles after assertion, ack enters handler.
    irq_enable = 15'h7FFF; global_ie = 1'b1; irq_in = 15'h0080;
    cycle(1);
    check("irq7.pending", 32'(irq_pending), 32'h0080);
    check_req("irq7.c1", 1'b0, 4'd0);
    cycle(1);
    check_req("irq7.c2", 1'b1, 4'd7);
    interrupt_ack = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0;
    check_req("irq7.acked", 1'b0, 4'd0);
    check("irq7.in_handler", 32'(in_handler), 32'd1);
    irq_in = '0; trap_ret = 1'b1;
    cycle(1);
    trap_ret = 1'b0;
    check("irq7.ret", 32'(in_handler), 32'd0);

    // Latched number holds against a higher-priority arrival.
    irq_in = 15'h0008;
    cycle(2);
    check_req("hold.first", 1'b1, 4'd3);
    irq_in = 15'h0808;
    cycle(2);
    check_req("hold.after11", 1'b1, 4'd3);
    interrupt_ack = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0;
    irq_in = 15'h0800; trap_ret = 1'b1;
    cycle(1);
    trap_ret = 1'b0;
    check_req("hold.ret", 1'b0, 4'd0);
    cycle(1);
    check_req("hold.next11", 1'b1, 4'd11);
    interrupt_ack = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0; irq_in = '0; trap_ret = 1'b1;
    cycle(1);
    trap_ret = 1'b0;

    // Withdraw when the latched source drops.
    irq_in = 15'h0020;
    cycle(2);
    check_req("wd5.req", 1'b1, 4'd5);
    irq_in = '0;
    cycle(2);
    check_req("wd5.gone", 1'b0, 4'd0);
    check("wd5.in_handler", 32'(in_handler), 32'd0);

    // Withdraw on global_ie clear; no request while it stays low.
    irq_in = 15'h0040;
    cycle(2);
    check_req("wdie.req", 1'b1, 4'd6);
    global_ie = 1'b0;
    cycle(1);
    check_req("wdie.gone", 1'b0, 4'd0);
    cycle(2);
    check_req("wdie.masked", 1'b0, 4'd0);
    irq_in = '0; global_ie = 1'b1;
    cycle(2);

    // Ack in IDLE is ignored.
    interrupt_ack = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0;
    check("ack_idle.in_handler", 32'(in_handler), 32'd0);

    // Halt suppresses requests; ack wins over a simultaneous halt withdraw.
    irq_in = 15'h0002; halt = 1'b1;
    cycle(3);
    check_req("halt.blocked", 1'b0, 4'd0);
    halt = 1'b0;
    cycle(1);
    check_req("halt.released", 1'b1, 4'd1);
    interrupt_ack = 1'b1; halt = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0; halt = 1'b0;
    check("ackwins.in_handler", 32'(in_handler), 32'd1);

    // No nesting: source 9 waits for trap_ret, then requests one cycle after IDLE.
    irq_in = 15'h0200;
    cycle(3);
    check_req("nest.blocked", 1'b0, 4'd0);
    check("nest.in_handler", 32'(in_handler), 32'd1);
    trap_ret = 1'b1;
    cycle(1);
    trap_ret = 1'b0;
    check_req("nest.idle", 1'b0, 4'd0);
    cycle(1);
    check_req("nest.req9", 1'b1, 4'd9);
    interrupt_ack = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0;

    // Reset during HANDLER clears everything; source 2 re-requested two cycles later.
    irq_in = 15'h0004; reset = 1'b1;
    cycle(1);
    check_req("rst.req", 1'b0, 4'd0);
    check("rst.in_handler", 32'(in_handler), 32'd0);
    check("rst.pending", 32'(irq_pending), 32'd0);
    reset = 1'b0;
    cycle(1);
    check_req("rst.c1", 1'b0, 4'd0);
    cycle(1);
    check_req("rst.c2", 1'b1, 4'd2);

    // trap_ret in REQUEST is ignored.
    trap_ret = 1'b1;
    cycle(1);
    trap_ret = 1'b0;
    check_req("tret_req", 1'b1, 4'd2);

    // Enable mask hides source 14, so 13 is the top candidate.
    interrupt_ack = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0;
    irq_in = 15'h7FFF; irq_enable = 15'h3FFF; trap_ret = 1'b1;
    cycle(1);
    trap_ret = 1'b0;
    check("mask.pending", 32'(irq_pending), 32'h3FFF);
    cycle(1);
    check_req("mask.req13", 1'b1, 4'd13);

`ifdef RISCV_I32_IRQ_NMI_EN
    // NMI preempts the handler of 4 with global_ie low, then returns to it.
    reset = 1'b1; irq_in = '0; irq_enable = 15'h7FFF;
    cycle(1);
    reset = 1'b0; irq_in = 15'h0010;
    cycle(2);
    check_req("nmi.req4", 1'b1, 4'd4);
    interrupt_ack = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0; global_ie = 1'b0; nmi = 1'b1;
    cycle(2);
    check_req("nmi.req15", 1'b1, 4'd15);
    interrupt_ack = 1'b1;
    cycle(1);
    interrupt_ack = 1'b0; nmi = 1'b0;
    check_req("nmi.acked", 1'b0, 4'd0);
    trap_ret = 1'b1;
    cycle(1);
    trap_ret = 1'b0;
    check("nmi.back_in_handler", 32'(in_handler), 32'd1);
    check_req("nmi.back_req", 1'b0, 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
